// File: rtl/dsp_divider_pkg.sv
// Shared definitions for the iterative RV32M divider: FSM states and result constants.
package div_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIX,
        DONE
    } div_state_t;

    localparam int          DIV_ITERS     = 32;
    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN       = 32'h8000_0000;

endpackage

// File: rtl/dsp_divider_sub32.sv
// 32-bit subtractor for the divider's trial step: diff = a - b, borrow = (a < b) unsigned.
module dsp_sub32 #(
    parameter int USE_DSP = 1
) (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] diff,
    output logic        borrow
);

    generate
        if (USE_DSP != 0) begin : g_dsp
            // Same split as an SB_MAC16 in bypassed ADDSUB mode: two 16-bit halves,
            // with the top half's carry chained from the bottom half.
            logic [16:0] bot;
            logic [16:0] top;
            assign bot    = {1'b0, a[15:0]} - {1'b0, b[15:0]};
            assign top    = {1'b0, a[31:16]} - {1'b0, b[31:16]} - {16'b0, bot[16]};
            assign diff   = {top[15:0], bot[15:0]};
            assign borrow = top[16];
        end else begin : g_fabric
            logic [32:0] full;
            assign full   = {1'b0, a} - {1'b0, b};
            assign diff   = full[31:0];
            assign borrow = full[32];
        end
    endgenerate

endmodule

// File: rtl/dsp_divider.sv
// Restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle, start/done handshake.
module dsp_divider
    import div_pkg::*;
#(
    parameter int USE_DSP = 1,
    parameter int XLEN    = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            is_signed,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    div_state_t      state;
    logic [XLEN-1:0] q_reg;
    logic [XLEN-1:0] r_reg;
    logic [XLEN-1:0] d_reg;
    logic [4:0]      count;
    logic            op_signed;
    logic            neg_q;
    logic            neg_r;

    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] trial_lo;
    logic            trial_borrow;
    logic            no_borrow;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] d_abs;

    assign shifted   = {r_reg, q_reg[XLEN-1]};
    assign no_borrow = shifted[XLEN] | ~trial_borrow;
    assign a_abs     = (op_signed && q_reg[XLEN-1]) ? -q_reg : q_reg;
    assign d_abs     = (op_signed && d_reg[XLEN-1]) ? -d_reg : d_reg;

    dsp_sub32 #(
        .USE_DSP(USE_DSP)
    ) u_sub (
        .a     (shifted[XLEN-1:0]),
        .b     (d_reg),
        .diff  (trial_lo),
        .borrow(trial_borrow)
    );

    // q_reg holds the raw dividend until PREP, then the magnitude being shifted into quotient bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            q_reg     <= '0;
            r_reg     <= '0;
            d_reg     <= '0;
            count     <= '0;
            op_signed <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        q_reg     <= dividend;
                        d_reg     <= divisor;
                        op_signed <= is_signed;
                        busy      <= 1'b1;
                        state     <= PREP;
                    end
                end
                PREP: begin
                    if (d_reg == '0) begin
                        quotient  <= DIV_BY_ZERO_Q;
                        remainder <= q_reg;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else if (op_signed && q_reg == INT_MIN && d_reg == '1) begin
                        quotient  <= INT_MIN;
                        remainder <= '0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        q_reg <= a_abs;
                        d_reg <= d_abs;
                        neg_q <= op_signed & (q_reg[XLEN-1] ^ d_reg[XLEN-1]);
                        neg_r <= op_signed & q_reg[XLEN-1];
                        r_reg <= '0;
                        count <= '0;
                        state <= ITER;
                    end
                end
                ITER: begin
                    if (no_borrow) begin
                        r_reg <= trial_lo;
                        q_reg <= {q_reg[XLEN-2:0], 1'b1};
                    end else begin
                        r_reg <= shifted[XLEN-1:0];
                        q_reg <= {q_reg[XLEN-2:0], 1'b0};
                    end
                    count <= count + 5'd1;
                    if (count == 5'(DIV_ITERS - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    quotient  <= neg_q ? -q_reg : q_reg;
                    remainder <= neg_r ? -r_reg : r_reg;
                    done      <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dsp_divider.sv
// Self-checking bench for dsp_divider: directed RV32M corner cases plus randomized operands.
module tb_dsp_divider;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int compared = 0;
    int mismatched = 0;

    dsp_divider #(
        .USE_DSP(1),
        .XLEN   (32)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .is_signed(is_signed),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .quotient (quotient),
        .remainder(remainder)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // RV32M reference semantics computed directly with SV arithmetic.
    function automatic void refDiv(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                   output logic [31:0] q, output logic [31:0] r, output int lat);
        int          sa;
        int          sb;
        int unsigned ua;
        int unsigned ub;
        sa = a; sb = b; ua = a; ub = b;
        lat = 35;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a; lat = 2;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 32'd0; lat = 2;
        end else if (sgn) begin
            q = sa / sb; r = sa % sb;
        end else begin
            q = ua / ub; r = ua % ub;
        end
    endfunction

    // Issues one request at the next falling edge and follows it until done.
    // If inject_at > 0, a second start with other operands is driven at edge T+inject_at.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                 input int inject_at, input string tag);
        logic [31:0] exp_q;
        logic [31:0] exp_r;
        int          exp_lat;
        int          first_done;
        logic        busy_ok;
        refDiv(a, b, sgn, exp_q, exp_r, exp_lat);
        @(negedge clk);
        dividend = a; divisor = b; is_signed = sgn; start = 1'b1;
        @(posedge clk);
        first_done = -1;
        busy_ok = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (inject_at > 0 && k == inject_at) begin
                start = 1'b1; dividend = $urandom; divisor = $urandom | 32'd1; is_signed = ~sgn;
            end
            if (inject_at > 0 && k == inject_at + 1) start = 1'b0;
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                first_done = k;
                break;
            end
        end
        checkOutput({tag, "_done_latency"}, first_done, exp_lat);
        checkOutput({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
        checkOutput({tag, "_quotient"}, quotient, exp_q);
        checkOutput({tag, "_remainder"}, remainder, exp_r);
    endtask

    initial begin
        int pulses;
        logic [31:0] ra;
        logic [31:0] rb;
        $display("[TB] dsp_divider bench starting");

        #12;
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_quotient", quotient, 32'd0);
        checkOutput("reset_remainder", remainder, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(32'd100, 32'd7, 1'b0, 0, "u100_7");
        @(negedge clk);
        checkOutput("idle_busy_after_done", {31'd0, busy}, 32'd0);
        checkOutput("idle_done_after_done", {31'd0, done}, 32'd0);

        applyStimulus(32'hFFFF_FFF9, 32'h2, 1'b1, 0, "s_m7_2");
        applyStimulus(32'hFFFF_FFF9, 32'h2, 1'b0, 0, "u_m7_2");
        applyStimulus(32'h0000_1234, 32'h0, 1'b1, 0, "s_div0");
        applyStimulus(32'h0000_1234, 32'h0, 1'b0, 0, "u_div0");
        applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, "s_overflow");
        applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, "u_overflow_ops");
        applyStimulus(32'hFFFF_FFFF, 32'h1, 1'b0, 0, "u_max_1");
        applyStimulus(32'hDEAD_BEEF, 32'h0000_1234, 1'b1, 10, "ignored_start");
        applyStimulus(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 0, "back_to_back");

        // Abort a division during ITER and confirm no done pulse follows.
        @(negedge clk);
        dividend = 32'd1000; divisor = 32'd3; is_signed = 1'b0; start = 1'b1;
        @(posedge clk);
        for (int k = 1; k < 15; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_done", {31'd0, done}, 32'd0);
        checkOutput("abort_quotient", quotient, 32'd0);
        checkOutput("abort_remainder", remainder, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        checkOutput("abort_no_activity", pulses, 32'd0);
        applyStimulus(32'd9, 32'd3, 1'b0, 0, "after_reset_9_3");

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0: begin ra = $urandom; rb = $urandom; end
                1: begin ra = $urandom; rb = $urandom_range(1, 17); end
                2: begin ra = $urandom; rb = 32'd0; end
                default: begin
                    ra = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : $urandom;
                    rb = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : (32'hFFFF_FF00 | $urandom_range(0, 255));
                end
            endcase
            applyStimulus(ra, rb, 1'($urandom_range(0, 1)), 0, $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dsp_divider.md
Name: dsp_divider

Overview:
- Iterative 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU path in the sail-core execute stage.
- This is the subtract-direction counterpart of the DSP adder. It runs a restoring division, one quotient bit per cycle.
- The trial subtraction is mapped onto an SB_MAC16 configured as a bypassed 32-bit subtractor.
- The block takes a one-cycle start pulse and returns the quotient and remainder with a one-cycle done pulse.

Parameters:
- USE_DSP, 1: 1 = trial subtract in SB_MAC16 (ADDSUBTOP/ADDSUBBOT = 1, bypass outputs, no input/output registers); 0 = fabric subtractor, bit-identical result.
- XLEN, 32: operand width; only 32 is supported.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request pulse; sampled only in IDLE
- is_signed  input  1  1 = DIV/REM semantics, 0 = DIVU/REMU
- dividend  input  32  numerator, captured when start is accepted
- divisor  input  32  denominator, captured when start is accepted
- busy  output  1  high from the cycle after accept until done inclusive
- done  output  1  one-cycle pulse; results are valid from this cycle on
- quotient  output  32  result, held until the next accepted start
- remainder  output  32  result, held until the next accepted start

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE; busy=0, done=0, quotient=0, remainder=0; internal registers cleared.
- Reset asserted mid-operation aborts the division. No done pulse is issued for the aborted request.
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE, start=1 at edge T: latch operands and is_signed; go to PREP.
- start is ignored while busy=1.
- PREP (cycle T+1), shortcut cases are checked first:
  - Divisor == 0: quotient=0xFFFFFFFF, remainder=dividend; go to DONE. done is high at T+2.
  - is_signed and dividend == 0x80000000 and divisor == 0xFFFFFFFF: quotient=0x80000000, remainder=0; go to DONE. done is high at T+2.
  - Otherwise: take absolute values when signed; record neg_q = sign(dividend) XOR sign(divisor) and neg_r = sign(dividend); clear R; load Q = |dividend|; count=0; go to ITER.
- ITER (32 cycles, T+2..T+33), each cycle:
  - shifted = {R, Q[31]} (33 bits).
  - trial = shifted − {1'b0, |divisor|}. The low 32 bits are computed by dsp_sub32 and the borrow is extended with shifted[32].
  - No borrow: R = trial[31:0], Q = {Q[30:0], 1}.
  - Borrow: R = shifted[31:0], Q = {Q[30:0], 0}.
  - count increments each cycle; count == 31 moves to FIX.
- FIX (T+34): quotient = neg_q ? −Q : Q; remainder = neg_r ? −R : R. Go to DONE.
- DONE: done=1 for exactly one cycle (T+35 on the normal path); busy=1 in this cycle; next state IDLE.
- Latency: 35 cycles normal, 2 cycles shortcut. A start may be accepted the cycle after done (back-to-back).
- Width rules: all arithmetic is modulo 2^32 apart from the 33-bit trial. Sign-correction negation is two's complement.
- Remainder sign follows the dividend; the quotient truncates toward zero.
- Unsigned mode never negates, even when operand bit 31 is set.

Decomposition:
- Shared package (div_pkg):
  - state enum {IDLE, PREP, ITER, FIX, DONE};
  - constants DIV_ITERS=32, DIV_BY_ZERO_Q=32'hFFFFFFFF, INT_MIN=32'h80000000.
- Sub-module dsp_sub32:
  - ports a[31:0], b[31:0], diff[31:0], borrow;
  - an SB_MAC16 with A/B = a halves and C/D = b halves, ADDSUB bits set, top carry chained from bottom, outputs bypassed;
  - USE_DSP=0 selects the fabric generate branch.

Test Plan:
- Unsigned 100 / 7, start at T: done=1 only at T+35; quotient=14, remainder=2; busy high T+1..T+35.
- Signed −7 / 2 (0xFFFFFFF9, 0x2): quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. The same operands unsigned give quotient=0x7FFFFFFC, remainder=1.
- Divide by zero, 0x00001234 / 0: done at T+2, quotient=0xFFFFFFFF, remainder=0x00001234, in both signed and unsigned modes.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: done at T+2, quotient=0x80000000, remainder=0.
- Extremes and hazards:
  - 0xFFFFFFFF / 1 unsigned gives quotient=0xFFFFFFFF, remainder=0.
  - A second start at T+10 is ignored: results are unchanged and a single done pulse occurs.
  - A back-to-back start on the done cycle+1 is accepted.
- rst_n low at T+15 during ITER: outputs go to 0 immediately with no done pulse. After release, 9 / 3 gives quotient=3, remainder=0 at +35.
